// File: rtl/warmboot_ctrl.sv
// warmboot_ctrl: holds the fabric in reset, requests a slot bitstream from the loader,
// releases the fabric once loaded, and falls back once to golden slot 0 on load error.
module warmboot_ctrl #(
    parameter int SLOT_BITS      = 4,
    parameter int ADDR_WIDTH     = 24,
    parameter int BASE_ADDR      = 0,
    parameter int SLOT_SHIFT     = 16,
    parameter int RESET_CYCLES   = 16,
    parameter int RELEASE_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  boot_i,
    input  logic [SLOT_BITS-1:0]  slot_i,
    output logic                  fabric_reset_o,
    output logic                  configured_o,
    output logic                  cfg_req_o,
    output logic [ADDR_WIDTH-1:0] cfg_addr_o,
    input  logic                  cfg_ack_i,
    input  logic                  cfg_done_i,
    input  logic                  cfg_error_i,
    output logic [SLOT_BITS-1:0]  loaded_slot_o,
    output logic                  error_o
);
    typedef enum logic [2:0] {HOLD, REQ, LOAD, POST, IDLE, ERROR} state_t;

    localparam int MAX_CYCLES = RESET_CYCLES > RELEASE_CYCLES ? RESET_CYCLES : RELEASE_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] POST_LOAD = CW'(RELEASE_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    sync1_q, sync2_q, prev_q;
    logic                    fabric_reset_q, fabric_reset_d;
    logic                    configured_q, configured_d;
    logic                    cfg_req_q, cfg_req_d;
    logic [ADDR_WIDTH-1:0]   cfg_addr_q, cfg_addr_d;
    logic [SLOT_BITS-1:0]    loaded_slot_q, loaded_slot_d;
    logic                    error_q, error_d;
    logic                    fallback_q, fallback_d;
    logic                    boot_edge;
    logic [ADDR_WIDTH-1:0]   slot_addr;

    assign boot_edge = sync2_q & ~prev_q;
    // Address arithmetic wraps naturally at ADDR_WIDTH bits.
    assign slot_addr = BASE + (ADDR_WIDTH'(loaded_slot_q) << SLOT_SHIFT);

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            state_q        <= HOLD;
            cnt_q          <= HOLD_LOAD;
            fabric_reset_q <= 1'b1;
            configured_q   <= 1'b0;
            cfg_req_q      <= 1'b0;
            cfg_addr_q     <= BASE;
            loaded_slot_q  <= '0;
            error_q        <= 1'b0;
            fallback_q     <= 1'b0;
        end else begin
            sync1_q        <= boot_i;
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fabric_reset_q <= fabric_reset_d;
            configured_q   <= configured_d;
            cfg_req_q      <= cfg_req_d;
            cfg_addr_q     <= cfg_addr_d;
            loaded_slot_q  <= loaded_slot_d;
            error_q        <= error_d;
            fallback_q     <= fallback_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        fabric_reset_d = fabric_reset_q;
        configured_d   = configured_q;
        cfg_req_d      = cfg_req_q;
        cfg_addr_d     = cfg_addr_q;
        loaded_slot_d  = loaded_slot_q;
        error_d        = error_q;
        fallback_d     = fallback_q;
        case (state_q)
            IDLE: if (boot_edge) begin
                loaded_slot_d  = slot_i;
                fallback_d     = 1'b0;
                fabric_reset_d = 1'b1;
                configured_d   = 1'b0;
                cnt_d          = HOLD_LOAD;
                state_d        = HOLD;
            end
            HOLD: begin
                cfg_addr_d = slot_addr;
                if (cnt_q == '0) begin
                    cfg_req_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REQ: if (cfg_ack_i) begin
                cfg_req_d = 1'b0;
                state_d   = LOAD;
            end
            LOAD: if (cfg_done_i) begin
                if (!cfg_error_i) begin
                    cnt_d   = POST_LOAD;
                    state_d = POST;
                end else if (loaded_slot_q != '0 && !fallback_q) begin
                    loaded_slot_d = '0;
                    fallback_d    = 1'b1;
                    cnt_d         = HOLD_LOAD;
                    state_d       = HOLD;
                end else begin
                    error_d        = 1'b1;
                    fabric_reset_d = 1'b1;
                    configured_d   = 1'b0;
                    cfg_req_d      = 1'b0;
                    state_d        = ERROR;
                end
            end
            POST: begin
                if (cnt_q == '0) begin
                    fabric_reset_d = 1'b0;
                    configured_d   = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ERROR: ;
            default: begin
                error_d        = 1'b1;
                fabric_reset_d = 1'b1;
                configured_d   = 1'b0;
                cfg_req_d      = 1'b0;
                state_d        = ERROR;
            end
        endcase
    end

    assign fabric_reset_o = fabric_reset_q;
    assign configured_o   = configured_q;
    assign cfg_req_o      = cfg_req_q;
    assign cfg_addr_o     = cfg_addr_q;
    assign loaded_slot_o  = loaded_slot_q;
    assign error_o        = error_q;
endmodule

// File: tb/tb_warmboot_ctrl.sv
// tb_warmboot_ctrl: directed boot scenarios with randomized slots and loader delays
module tb_warmboot_ctrl;
    localparam int SB = 4, AW = 24, BASE = 0, SHIFT = 16, RC = 16, RLC = 8;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          boot_i = 1'b0;
    logic [SB-1:0] slot_i = '0;
    logic          fabric_reset_o, configured_o, cfg_req_o, error_o;
    logic [AW-1:0] cfg_addr_o;
    logic          cfg_ack_i = 1'b0, cfg_done_i = 1'b0, cfg_error_i = 1'b0;
    logic [SB-1:0] loaded_slot_o;
    int checks = 0, errors = 0;

    warmboot_ctrl #(.SLOT_BITS(SB), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .SLOT_SHIFT(SHIFT),
                    .RESET_CYCLES(RC), .RELEASE_CYCLES(RLC)) dut (
        .CLK(CLK), .resetn(resetn), .boot_i(boot_i), .slot_i(slot_i),
        .fabric_reset_o(fabric_reset_o), .configured_o(configured_o),
        .cfg_req_o(cfg_req_o), .cfg_addr_o(cfg_addr_o), .cfg_ack_i(cfg_ack_i),
        .cfg_done_i(cfg_done_i), .cfg_error_i(cfg_error_i),
        .loaded_slot_o(loaded_slot_o), .error_o(error_o));

    always #5 CLK = ~CLK;

    function automatic logic [31:0] exp_addr(input int slot);
        longint a;
        a = (longint'(BASE) + longint'(slot) * (longint'(1) << SHIFT)) % (longint'(1) << AW);
        return 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_frst"}, 32'(fabric_reset_o), 1);
        chk({tag, "_cfgd"}, 32'(configured_o), 0);
        chk({tag, "_req"}, 32'(cfg_req_o), 0);
        chk({tag, "_addr"}, 32'(cfg_addr_o), exp_addr(0));
        chk({tag, "_slot"}, 32'(loaded_slot_o), 0);
        chk({tag, "_err"}, 32'(error_o), 0);
    endtask

    task automatic wait_req(input string tag, input int exp_slot);
        int n = 0;
        while (n < 200) begin
            step(1);
            n++;
            if (cfg_req_o) break;
        end
        chk({tag, "_req_lat"}, 32'(n), RC);
        chk({tag, "_addr"}, 32'(cfg_addr_o), exp_addr(exp_slot));
        chk({tag, "_slot"}, 32'(loaded_slot_o), 32'(exp_slot));
        chk({tag, "_hold_rst"}, {30'b0, fabric_reset_o, configured_o}, 32'b10);
    endtask

    task automatic serve_req(input string tag, input int ack_dly, input bit done_with_ack);
        logic [AW-1:0] a = cfg_addr_o;
        step(ack_dly);
        chk({tag, "_req_held"}, {31'b0, cfg_req_o}, 1);
        chk({tag, "_addr_stable"}, 32'(cfg_addr_o), 32'(a));
        cfg_ack_i = 1'b1;
        cfg_done_i = done_with_ack;
        step(1);
        cfg_ack_i = 1'b0;
        cfg_done_i = 1'b0;
        chk({tag, "_req_drop"}, {31'b0, cfg_req_o}, 0);
    endtask

    task automatic finish_load(input string tag, input int dly, input bit err);
        step(dly);
        chk({tag, "_pre_done"}, {30'b0, fabric_reset_o, configured_o}, 32'b10);
        cfg_done_i = 1'b1;
        cfg_error_i = err;
        step(1);
        cfg_done_i = 1'b0;
        cfg_error_i = 1'b0;
    endtask

    task automatic chk_release(input string tag);
        int n = 0;
        while (n < 200) begin
            step(1);
            n++;
            if (configured_o) break;
        end
        chk({tag, "_rel_lat"}, 32'(n), RLC);
        chk({tag, "_rel_frst"}, {31'b0, fabric_reset_o}, 0);
        chk({tag, "_rel_err"}, {31'b0, error_o}, 0);
    endtask

    task automatic trigger_boot(input string tag, input int slot);
        boot_i = 1'b0;
        slot_i = SB'(slot);
        step(4);
        boot_i = 1'b1;
        step(2);
        chk({tag, "_pre_edge"}, {31'b0, fabric_reset_o}, 0);
        step(1);
        chk({tag, "_boot_frst"}, {30'b0, fabric_reset_o, configured_o}, 32'b10);
        chk({tag, "_latched"}, 32'(loaded_slot_o), 32'(slot));
    endtask

    initial begin
        int slot, req_seen;
        step(2);
        chk_reset_vals("por");
        resetn = 1'b1;
        // cold boot
        wait_req("cold", 0);
        serve_req("cold", 0, 1'b0);
        finish_load("cold", 10, 1'b0);
        chk_release("cold");
        // warm boot slot 3, boot_i left high throughout; early done with ack is ignored
        trigger_boot("s3", 3);
        wait_req("s3", 3);
        serve_req("s3", 2, 1'b1);
        finish_load("s3", 10, 1'b0);
        chk_release("s3");
        step(10);
        chk("s3_held_high_once", {31'b0, fabric_reset_o}, 0);
        boot_i = 1'b0;
        // randomized warm boots
        for (int i = 0; i < 4; i++) begin
            slot = int'($urandom_range(1, 15));
            trigger_boot("rnd", slot);
            boot_i = 1'b0;
            wait_req("rnd", slot);
            serve_req("rnd", int'($urandom_range(0, 3)), 1'b0);
            finish_load("rnd", int'($urandom_range(1, 12)), 1'b0);
            chk_release("rnd");
        end
        // fallback to golden
        trigger_boot("fb", 5);
        boot_i = 1'b0;
        wait_req("fb", 5);
        serve_req("fb", 1, 1'b0);
        finish_load("fb", 4, 1'b1);
        wait_req("fb_gold", 0);
        serve_req("fb_gold", 0, 1'b0);
        finish_load("fb_gold", 3, 1'b0);
        chk_release("fb_gold");
        // double failure
        trigger_boot("df", 5);
        boot_i = 1'b0;
        wait_req("df", 5);
        serve_req("df", 0, 1'b0);
        finish_load("df", 2, 1'b1);
        wait_req("df_gold", 0);
        serve_req("df_gold", 0, 1'b0);
        finish_load("df_gold", 2, 1'b1);
        chk("df_err", {28'b0, error_o, fabric_reset_o, configured_o, cfg_req_o}, 32'b1100);
        req_seen = 0;
        for (int i = 0; i < 60; i++) begin
            boot_i = (i % 8) >= 4;
            step(1);
            req_seen += int'(cfg_req_o);
        end
        boot_i = 1'b0;
        chk("df_no_req", 32'(req_seen), 0);
        chk("df_err_stuck", {29'b0, error_o, fabric_reset_o, configured_o}, 32'b110);
        // reset out of ERROR, cold boot with boot pulse during LOAD
        resetn = 1'b0;
        #1;
        chk_reset_vals("rst_err");
        step(1);
        resetn = 1'b1;
        wait_req("cold2", 0);
        serve_req("cold2", 1, 1'b0);
        slot_i = 4'd9;
        boot_i = 1'b1;
        step(3);
        boot_i = 1'b0;
        finish_load("cold2", 6, 1'b0);
        chk_release("cold2");
        step(30);
        chk("discard_boot", {30'b0, fabric_reset_o, configured_o}, 32'b01);
        // reset while request pending
        trigger_boot("s7", 7);
        boot_i = 1'b0;
        wait_req("s7", 7);
        resetn = 1'b0;
        #1;
        chk_reset_vals("rst_req");
        step(1);
        resetn = 1'b1;
        wait_req("cold3", 0);
        serve_req("cold3", 0, 1'b0);
        finish_load("cold3", 5, 1'b0);
        chk_release("cold3");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
